// File: rtl/rll_key_pkg.sv
// Shared types, default sizes and the checksum fold for the RLL key loader.
package rll_key_pkg;

    localparam int unsigned KEY_W_DEF    = 32;
    localparam int unsigned CHK_W_DEF    = 8;
    localparam int unsigned MAX_FAIL_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_APPLY   = 3'd3,
        ST_DONE    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    // XOR of all CHK_W-bit chunks of the key
    function automatic logic [CHK_W_DEF-1:0] chk_fold(input logic [KEY_W_DEF-1:0] key);
        logic [CHK_W_DEF-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < KEY_W_DEF / CHK_W_DEF; i++) begin
            acc = acc ^ key[i*CHK_W_DEF +: CHK_W_DEF];
        end
        return acc;
    endfunction

endpackage

// File: rtl/rll_key_shifter.sv
// Serial LSB-first shift register splitting the stream into key and checksum.
module rll_key_shifter #(
    parameter int unsigned KEY_W = 32,
    parameter int unsigned CHK_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [KEY_W-1:0] key,
    output logic [CHK_W-1:0] chk,
    output logic             last_c,
    output logic             done_c
);

    localparam int unsigned TOT_W = KEY_W + CHK_W;
    localparam int unsigned CNT_W = $clog2(TOT_W + 1);

    logic [TOT_W-1:0] sr;
    logic [CNT_W-1:0] cnt;

    // New bits enter at the top so the first bit ends up at bit 0
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift_en && !done_c) begin
            sr  <= {bit_in, sr[TOT_W-1:1]};
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign key    = sr[KEY_W-1:0];
    assign chk    = sr[TOT_W-1:KEY_W];
    assign last_c = (cnt == CNT_W'(TOT_W - 1));
    assign done_c = (cnt == CNT_W'(TOT_W));

endmodule

// File: rtl/rll_key_loader.sv
// Loads, verifies and applies the unlock key of an RLL-locked netlist.
// Define RLL_KEY_ZEROIZE_EN to clear key_out on reload, mismatch and lockout.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int unsigned KEY_W    = KEY_W_DEF,
    parameter int unsigned CHK_W    = CHK_W_DEF,
    parameter int unsigned MAX_FAIL = MAX_FAIL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_abort,
    input  logic             key_bit,
    input  logic             key_bit_valid,
    output logic             key_bit_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy,
    output logic             locked_out,
    output logic [3:0]       fail_cnt
);

    localparam logic [2:0] IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] SHIFT   = 3'(ST_SHIFT);
    localparam logic [2:0] CHECK   = 3'(ST_CHECK);
    localparam logic [2:0] APPLY   = 3'(ST_APPLY);
    localparam logic [2:0] DONE    = 3'(ST_DONE);
    localparam logic [2:0] LOCKOUT = 3'(ST_LOCKOUT);

`ifdef RLL_KEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [KEY_W-1:0] key_out_nx;
    logic             key_valid_nx;
    logic             key_err_nx;
    logic [3:0]       fail_cnt_nx;
    logic             clear_c;
    logic             shift_en_c;
    logic             last_c;
    logic             done_c;
    logic [KEY_W-1:0] shadow_key;
    logic [CHK_W-1:0] rx_chk;
    logic [CHK_W-1:0] fold_c;

    rll_key_shifter #(
        .KEY_W (KEY_W),
        .CHK_W (CHK_W)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_c),
        .shift_en (shift_en_c),
        .bit_in   (key_bit),
        .key      (shadow_key),
        .chk      (rx_chk),
        .last_c   (last_c),
        .done_c   (done_c)
    );

    generate
        if (KEY_W == KEY_W_DEF && CHK_W == CHK_W_DEF) begin : g_pkg_fold
            assign fold_c = chk_fold(shadow_key);
        end else begin : g_gen_fold
            always_comb begin
                fold_c = '0;
                for (int unsigned i = 0; i < KEY_W / CHK_W; i++) begin
                    fold_c = fold_c ^ shadow_key[i*CHK_W +: CHK_W];
                end
            end
        end
    endgenerate

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        key_out_nx   = key_out;
        key_valid_nx = key_valid;
        key_err_nx   = 1'b0;
        fail_cnt_nx  = fail_cnt;
        clear_c      = 1'b0;
        shift_en_c   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load_start) begin
                    state_nx     = SHIFT;
                    key_valid_nx = 1'b0;
                    clear_c      = 1'b1;
                    if (ZEROIZE) key_out_nx = '0;
                end
            end
            SHIFT: begin
                if (load_abort) begin
                    state_nx = IDLE;
                    clear_c  = 1'b1;
                end else if (key_bit_valid) begin
                    shift_en_c = 1'b1;
                    if (last_c) state_nx = CHECK;
                end
            end
            CHECK: begin
                if (done_c && fold_c == rx_chk) begin
                    state_nx    = APPLY;
                    fail_cnt_nx = '0;
                end else begin
                    key_err_nx   = 1'b1;
                    key_valid_nx = 1'b0;
                    if (ZEROIZE) key_out_nx = '0;
                    if (fail_cnt < 4'(MAX_FAIL)) fail_cnt_nx = fail_cnt + 4'd1;
                    state_nx = (fail_cnt_nx == 4'(MAX_FAIL)) ? LOCKOUT : IDLE;
                end
            end
            APPLY: begin
                key_out_nx   = shadow_key;
                key_valid_nx = 1'b1;
                state_nx     = DONE;
            end
            LOCKOUT: begin
                state_nx = LOCKOUT;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            key_out       <= '0;
            key_valid     <= 1'b0;
            key_err       <= 1'b0;
            fail_cnt      <= '0;
            key_bit_ready <= 1'b0;
            busy          <= 1'b0;
            locked_out    <= 1'b0;
        end else begin
            state         <= state_nx;
            key_out       <= key_out_nx;
            key_valid     <= key_valid_nx;
            key_err       <= key_err_nx;
            fail_cnt      <= fail_cnt_nx;
            key_bit_ready <= (state_nx == SHIFT);
            busy          <= (state_nx == SHIFT) || (state_nx == CHECK) || (state_nx == APPLY);
            locked_out    <= (state_nx == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Scoreboard bench for rll_key_loader; honours RLL_KEY_ZEROIZE_EN when defined.
module tb_rll_key_loader;

    localparam int unsigned KW = 32;
    localparam int unsigned MF = 3;

    typedef struct packed {
        logic [31:0] key;
        logic        err;
        logic [3:0]  fail;
        logic        lock;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic          load_abort;
    logic          key_bit;
    logic          key_bit_valid;
    logic          key_bit_ready;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          key_err;
    logic          busy;
    logic          locked_out;
    logic [3:0]    fail_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    logic [31:0] m_key    = '0;
    logic [3:0]  m_fail   = '0;
    bit          m_locked = 1'b0;

    always #5 clk = ~clk;

    rll_key_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_abort    (load_abort),
        .key_bit       (key_bit),
        .key_bit_valid (key_bit_valid),
        .key_bit_ready (key_bit_ready),
        .key_out       (key_out),
        .key_valid     (key_valid),
        .key_err       (key_err),
        .busy          (busy),
        .locked_out    (locked_out),
        .fail_cnt      (fail_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] tb_fold(input logic [31:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
    endfunction

    // Output monitor: every key_valid rise or key_err pulse consumes one expectation
    logic prev_kv  = 1'b0;
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if ((key_valid && !prev_kv) || key_err) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 64'(sb_q.size()), 1);
            end else begin
                e = sb_q.pop_front();
                check("sb_err", key_err, e.err);
                check("sb_key", key_out, e.key);
                check("sb_fail", fail_cnt, e.fail);
                check("sb_lock", locked_out, e.lock);
            end
            if (key_err) check("err_width", prev_err, 0);
        end
        prev_kv  = key_valid;
        prev_err = key_err;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        load_start = 1'b0;
        load_abort = 1'b0;
        key_bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_key = '0;
        m_fail = '0;
        m_locked = 1'b0;
        check("rst_key_out", key_out, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_err", key_err, 0);
        check("rst_ready", key_bit_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_locked", locked_out, 0);
        check("rst_fail_cnt", fail_cnt, 0);
    endtask

    task automatic start_load(input bit with_abort);
        load_start = 1'b1;
        load_abort = with_abort;
        @(negedge clk);
        load_start = 1'b0;
        load_abort = 1'b0;
`ifdef RLL_KEY_ZEROIZE_EN
        if (!m_locked) m_key = '0;
`endif
        check("start_kv", key_valid, 0);
        check("start_ready", key_bit_ready, !m_locked);
        check("start_key", key_out, m_key);
    endtask

    task automatic send_bits(input logic [39:0] data, input bit toggle, input int n);
        for (int i = 0; i < n; i++) begin
            if (toggle && i > 0) begin
                key_bit_valid = 1'b0;
                @(negedge clk);
                if (!m_locked) check("stall_busy", busy, 1);
            end
            key_bit = data[i];
            key_bit_valid = 1'b1;
            @(negedge clk);
            check("load_kv", key_valid, 0);
        end
        key_bit_valid = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] k, input logic [7:0] c, input bit toggle,
                            input bit with_abort);
        bit   was_locked;
        logic err;
        was_locked = m_locked;
        start_load(with_abort);
        send_bits({c, k}, toggle, 40);
        if (!was_locked) begin
            err = (tb_fold(k) != c);
            if (!err) begin
                m_key  = k;
                m_fail = '0;
            end else begin
                if (m_fail < 4'(MF)) m_fail = m_fail + 4'd1;
`ifdef RLL_KEY_ZEROIZE_EN
                m_key = '0;
`endif
                if (m_fail == 4'(MF)) m_locked = 1'b1;
            end
            sb_q.push_back('{key: m_key, err: err, fail: m_fail, lock: m_locked});
            check("lat_e0", key_valid, 0);
            @(negedge clk);
            check("lat_e1", key_valid, 0);
            @(negedge clk);
            check("lat_e2", key_valid, !err);
            check("end_err_clear", key_err, 0);
            check("end_busy", busy, 0);
            check("end_fail_cnt", fail_cnt, m_fail);
            check("end_key", key_out, m_key);
        end else begin
            repeat (2) @(negedge clk);
            check("lock_kv", key_valid, 0);
            check("lock_flag", locked_out, 1);
            check("lock_key", key_out, m_key);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        load_start = 1'b0;
        load_abort = 1'b0;
        key_bit = 1'b0;
        key_bit_valid = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Good load, continuous stream, then the same with valid gaps (reload from DONE)
        load_key(32'h1234_5678, 8'h08, 1'b0, 1'b0);
        load_key(32'h1234_5678, 8'h08, 1'b1, 1'b0);

        // Reload aborted after 10 bits; abort coincides with a valid bit
        start_load(1'b0);
        send_bits({8'h22, 32'hDEAD_BEEF}, 1'b0, 10);
        key_bit = 1'b1;
        key_bit_valid = 1'b1;
        load_abort = 1'b1;
        @(negedge clk);
        load_abort = 1'b0;
        key_bit_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", key_bit_ready, 0);
        check("abort_kv", key_valid, 0);
        check("abort_err", key_err, 0);
        check("abort_fail", fail_cnt, m_fail);
        check("abort_key", key_out, m_key);

        // Abort in IDLE is ignored
        load_abort = 1'b1;
        @(negedge clk);
        load_abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_key", key_out, m_key);

        // Three bad loads lead to lockout; a good load afterwards is ignored
        for (int i = 0; i < 3; i++) load_key(32'h1234_5678, 8'h09, 1'b0, 1'b0);
        check("lockout_flag", locked_out, 1);
        check("lockout_fail", fail_cnt, MF);
        load_key(32'h1234_5678, 8'h08, 1'b0, 1'b0);
        check("lockout_hold_fail", fail_cnt, MF);

        // Reset mid-SHIFT, then a clean load started together with a stray abort
        do_reset();
        start_load(1'b0);
        send_bits({8'h00, 32'hA5A5_0F0F}, 1'b0, 12);
        do_reset();
        load_key(32'hA5A5_0F0F, 8'h00, 1'b0, 1'b1);
        check("final_key", key_out, 32'hA5A5_0F0F);
        check("final_valid", key_valid, 1);

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
